spi_loader_unpack: RTL and testbench

Downstream consumer of the SPI flash loader's 32-bit word FIFO. It pops words, splits them into narrower lanes and streams them to the accelerator datapath over a valid/ready handshake. It also drives the loader's fill request and counts words so that the host sees a single done pulse per transfer. It sits between the loader wrapper and the weight/code consumer, in the RISC-V clock domain.

---
 rtl/spi_loader_unpack_pkg.sv | 18 +
 rtl/spi_loader_unpack.sv | 128 ++++++++++++
 tb/tb_spi_loader_unpack.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_loader_unpack_pkg.sv
// Shared types and constants for the SPI loader word unpacker.
// Used by spi_loader_unpack; the optional checksum width lives here too.
package spi_loader_unpack_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WORD_W = 32;
   localparam int CSUM_W = 16;

   function automatic int lanes_of(input int out_w);
      return WORD_W / out_w;
   endfunction

endpackage

// File: rtl/spi_loader_unpack.sv
// Pops 32-bit words from the SPI loader FIFO and streams them out as OUT_W-bit lanes, lane 0 first.
// Optional running lane checksum on o_csum when SPI_LOADER_UNPACK_CSUM_EN is defined.
module spi_loader_unpack
   import spi_loader_unpack_pkg::*;
#(
   parameter int OUT_W = 8,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic [CNT_W-1:0]  i_words,
   output logic              o_fill,
   input  logic              i_fifo_empty,
   input  logic              i_fifo_low,
   output logic              o_fifo_rd,
   input  logic [WORD_W-1:0] i_fifo_dout,
   output logic              o_valid,
   output logic [OUT_W-1:0]  o_data,
   input  logic              i_ready,
   output logic              o_busy,
   output logic              o_done
`ifdef SPI_LOADER_UNPACK_CSUM_EN
   ,
   output logic [CSUM_W-1:0] o_csum
`endif
);

   localparam int LANES  = lanes_of(OUT_W);
   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    rd_left_q, out_left_q;
   logic                inflight_q;
   logic                full_q;
   logic [LIDX_W-1:0]   lane_q;
   logic [WORD_W-1:0]   word_q;
   logic                fill_q;
   logic                done_q;

   logic                hs;
   logic                last_hs;
   logic                final_hs;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      hs       = full_q & i_ready;
      last_hs  = hs & (lane_q == LAST_LANE);
      final_hs = last_hs & (out_left_q == CNT_W'(1));

      // A restart pops nothing in its own cycle, so the new transfer starts from the FIFO head.
      o_fifo_rd = (state_q == RUN) & ~i_start & (rd_left_q != '0) & ~i_fifo_empty
                & ~inflight_q & (~full_q | last_hs);

      state_d = state_q;
      unique case (state_q)
         IDLE:    if (i_start && i_words != '0) state_d = RUN;
         RUN:     if (final_hs) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (i_start) state_d = (i_words != '0) ? RUN : IDLE;
   end

   assign o_valid = full_q;
   assign o_data  = word_q[int'(lane_q) * OUT_W +: OUT_W];
   assign o_busy  = (state_q == RUN) | (state_q == DONE);
   assign o_fill  = fill_q;
   assign o_done  = done_q;

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rd_left_q  <= '0;
         out_left_q <= '0;
         inflight_q <= 1'b0;
         full_q     <= 1'b0;
         lane_q     <= '0;
         word_q     <= '0;
         fill_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_q     <= (state_q == RUN) & i_fifo_low & (rd_left_q != '0);
         done_q     <= i_start ? (i_words == '0) : final_hs;
         inflight_q <= o_fifo_rd;

         // Start outranks capture: the return of a read issued by the aborted transfer is dropped.
         if (i_start) begin
            rd_left_q  <= i_words;
            out_left_q <= i_words;
            full_q     <= 1'b0;
            lane_q     <= '0;
            word_q     <= '0;
         end else begin
            if (o_fifo_rd) rd_left_q <= rd_left_q - CNT_W'(1);
            if (inflight_q) begin
               word_q <= i_fifo_dout;
               full_q <= 1'b1;
               lane_q <= '0;
            end else if (hs) begin
               if (lane_q == LAST_LANE) begin
                  full_q     <= 1'b0;
                  lane_q     <= '0;
                  out_left_q <= out_left_q - CNT_W'(1);
               end else begin
                  lane_q <= lane_q + LIDX_W'(1);
               end
            end
         end
      end
   end

`ifdef SPI_LOADER_UNPACK_CSUM_EN
   logic [CSUM_W-1:0] csum_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        csum_q <= '0;
      else if (i_start) csum_q <= '0;
      else if (hs)      csum_q <= csum_q + CSUM_W'(o_data);
   end

   assign o_csum = csum_q;
`endif

endmodule

// File: tb/tb_spi_loader_unpack.sv
// Bench for spi_loader_unpack: an 8-bit instance checked every cycle against a lane-stream model,
// plus a 16-bit instance for the wide-lane case. Checksum checks follow SPI_LOADER_UNPACK_CSUM_EN.
module tb_spi_loader_unpack;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      n_checks++;
      n_errors++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- 8-bit instance ----------------
   logic        start_a = 1'b0;
   logic [15:0] words_a = '0;
   logic        fill_a, empty_a, rd_a, valid_a, busy_a, done_a;
   logic        low_a   = 1'b0;
   logic        ready_a = 1'b1;
   logic [31:0] dout_a  = '0;
   logic [7:0]  data_a;
   logic [31:0] mem_a [16];
   int          head_a = 0;
   int          tail_a = 0;
`ifdef SPI_LOADER_UNPACK_CSUM_EN
   logic [15:0] csum_a, csum_b;
`endif

   assign empty_a = (head_a >= tail_a);
   always @(posedge clk) if (rd_a) begin
      dout_a <= mem_a[head_a];
      head_a <= head_a + 1;
   end

   spi_loader_unpack #(.OUT_W(8), .CNT_W(16)) u_a (
      .clk          (clk),
      .reset        (reset),
      .i_start      (start_a),
      .i_words      (words_a),
      .o_fill       (fill_a),
      .i_fifo_empty (empty_a),
      .i_fifo_low   (low_a),
      .o_fifo_rd    (rd_a),
      .i_fifo_dout  (dout_a),
      .o_valid      (valid_a),
      .o_data       (data_a),
      .i_ready      (ready_a),
      .o_busy       (busy_a),
      .o_done       (done_a)
`ifdef SPI_LOADER_UNPACK_CSUM_EN
      ,
      .o_csum       (csum_a)
`endif
   );

   // ---------------- 16-bit instance ----------------
   logic        start_b = 1'b0;
   logic [15:0] words_b = '0;
   logic        fill_b, empty_b, rd_b, valid_b, busy_b, done_b;
   logic        low_b   = 1'b0;
   logic        ready_b = 1'b1;
   logic [31:0] dout_b  = '0;
   logic [15:0] data_b;
   logic [31:0] mem_b [4];
   int          head_b = 0;
   int          tail_b = 0;

   assign empty_b = (head_b >= tail_b);
   always @(posedge clk) if (rd_b) begin
      dout_b <= mem_b[head_b];
      head_b <= head_b + 1;
   end

   spi_loader_unpack #(.OUT_W(16), .CNT_W(16)) u_b (
      .clk          (clk),
      .reset        (reset),
      .i_start      (start_b),
      .i_words      (words_b),
      .o_fill       (fill_b),
      .i_fifo_empty (empty_b),
      .i_fifo_low   (low_b),
      .o_fifo_rd    (rd_b),
      .i_fifo_dout  (dout_b),
      .o_valid      (valid_b),
      .o_data       (data_b),
      .i_ready      (ready_b),
      .o_busy       (busy_b),
      .o_done       (done_b)
`ifdef SPI_LOADER_UNPACK_CSUM_EN
      ,
      .o_csum       (csum_b)
`endif
   );

   // ---------------- model of the 8-bit stream ----------------
   // The expected output is simply the little-endian lanes of the words the transfer owns.
   logic [7:0]  exp_a [$];
   logic [7:0]  log_a [$];
   int          hs_cyc_a [$];
   bit          act_a, done_next_a, after_start_a, stall_prev_a;
   logic [7:0]  stall_data_a;
   int          rd_cnt_a, words_m_a, done_cnt_a, done_cyc_a;
   logic [15:0] csum_m_a;

   always @(negedge clk) begin
      bit done_now, final_hs;
      logic [7:0] e;
      if (reset) begin
         exp_a.delete();
         act_a = 0; done_next_a = 0; after_start_a = 0; stall_prev_a = 0;
         rd_cnt_a = 0; csum_m_a = '0;
      end else begin
         done_now = done_next_a;
         check("a_busy", busy_a, act_a);
         check("a_done", done_a, done_now);
         if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
         end
`ifdef SPI_LOADER_UNPACK_CSUM_EN
         check("a_csum", csum_a, csum_m_a);
`endif
         if (after_start_a) check("a_valid_after_start", valid_a, 0);
         if (stall_prev_a) begin
            check("a_stall_valid", valid_a, 1);
            check("a_stall_data", data_a, stall_data_a);
         end
         check("a_rd_when_idle", rd_a & ~act_a, 0);
         if (rd_a) rd_cnt_a++;

         final_hs = 0;
         if (valid_a && ready_a) begin
            if (exp_a.size() == 0) begin
               fail_now("a_lane_extra", $sformatf("got lane %0h, expected no lane", data_a));
            end else begin
               e = exp_a.pop_front();
               check("a_lane", data_a, e);
               log_a.push_back(data_a);
               hs_cyc_a.push_back(cyc);
               csum_m_a = csum_m_a + 16'(data_a);
               if (exp_a.size() == 0 && act_a) begin
                  final_hs = 1;
                  check("a_rd_count", rd_cnt_a, words_m_a);
               end
            end
         end
         stall_prev_a = valid_a & ~ready_a;
         stall_data_a = data_a;

         after_start_a = start_a;
         if (start_a) begin
            exp_a.delete();
            for (int i = 0; i < int'(words_a); i++)
               for (int l = 0; l < 4; l++)
                  exp_a.push_back(mem_a[head_a + i][8*l +: 8]);
            act_a        = (words_a != 0);
            done_next_a  = (words_a == 0);
            words_m_a    = int'(words_a);
            rd_cnt_a     = 0;
            csum_m_a     = '0;
            stall_prev_a = 0;
         end else begin
            done_next_a = final_hs;
            if (done_now) act_a = 0;
         end
      end
   end

   // ---------------- model of the 16-bit stream ----------------
   logic [15:0] exp_b [$];
   logic [15:0] log_b [$];
   bit          done_next_b;
   int          rd_cnt_b, done_cnt_b;

   always @(negedge clk) begin
      logic [15:0] e;
      if (reset) begin
         exp_b.delete();
         done_next_b = 0;
      end else begin
         check("b_done", done_b, done_next_b);
         if (done_b) done_cnt_b++;
         if (rd_b) rd_cnt_b++;
         done_next_b = 0;
         if (valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
               fail_now("b_lane_extra", $sformatf("got lane %0h, expected no lane", data_b));
            end else begin
               e = exp_b.pop_front();
               check("b_lane", data_b, e);
               log_b.push_back(data_b);
               if (exp_b.size() == 0) done_next_b = 1;
            end
         end
         if (start_b) begin
            exp_b.delete();
            for (int i = 0; i < int'(words_b); i++)
               for (int l = 0; l < 2; l++)
                  exp_b.push_back(mem_b[head_b + i][16*l +: 16]);
            rd_cnt_b    = 0;
            done_next_b = (words_b == 0);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_xfer_a(input logic [15:0] n);
      log_a.delete();
      hs_cyc_a.delete();
      words_a = n;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string name, input int budget);
      int d0 = done_cnt_a;
      for (int i = 0; i < budget && done_cnt_a == d0; i++) tick();
      check(name, done_cnt_a != d0, 1);
   endtask

   task automatic wait_valid_a(input string name, input int budget);
      for (int i = 0; i < budget && !valid_a; i++) tick();
      check(name, valid_a, 1);
   endtask

   // Compares the captured stream against lanes of up to two hand-written words.
   task automatic check_log_a(input string name, input int nw,
                              input logic [31:0] w0, input logic [31:0] w1);
      logic [31:0] w;
      check({name, "_len"}, log_a.size(), nw * 4);
      for (int i = 0; i < nw * 4 && i < log_a.size(); i++) begin
         w = (i < 4) ? w0 : w1;
         check(name, log_a[i], w[8*(i%4) +: 8]);
      end
   endtask

   logic [7:0] t1_lanes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

   initial begin
      int s;
      int d0;
      for (int i = 0; i < 16; i++) mem_a[i] = '0;
      for (int i = 0; i < 4; i++)  mem_b[i] = '0;

      // Reset state
      #2 reset = 1'b1;
      #1;
      check("rst_valid", valid_a, 0);
      check("rst_data",  data_a, 0);
      check("rst_busy",  busy_a, 0);
      check("rst_done",  done_a, 0);
      check("rst_fill",  fill_a, 0);
      check("rst_rd",    rd_a, 0);
`ifdef SPI_LOADER_UNPACK_CSUM_EN
      check("rst_csum",  csum_a, 0);
`endif
      tick(); tick(); tick();
      reset = 1'b0;
      tick();

      // 16-bit lanes: CAFE then BEEF from one read
      mem_b[0] = 32'hBEEF_CAFE;
      tail_b   = 1;
      log_b.delete();
      d0       = done_cnt_b;
      words_b  = 16'd1;
      start_b  = 1'b1;
      tick();
      start_b  = 1'b0;
      for (int i = 0; i < 20 && done_cnt_b == d0; i++) tick();
      check("t16_done_seen", done_cnt_b != d0, 1);
      check("t16_len", log_b.size(), 2);
      if (log_b.size() == 2) begin
         check("t16_lane0", log_b[0], 16'hCAFE);
         check("t16_lane1", log_b[1], 16'hBEEF);
      end
      check("t16_rd_once", rd_cnt_b, 1);
`ifdef SPI_LOADER_UNPACK_CSUM_EN
      check("t16_csum", csum_b, 16'h89ED);
`endif
      tick();

      // 8-bit streaming of two words with ready held high
      mem_a[0] = 32'h4433_2211;
      mem_a[1] = 32'h8877_6655;
      tail_a   = 2;
      s        = cyc;
      start_xfer_a(16'd2);
      wait_done_a("t1_done_seen", 40);
      check("t1_len", log_a.size(), 8);
      for (int i = 0; i < 8 && i < log_a.size(); i++) check("t1_lane", log_a[i], t1_lanes[i]);
      if (hs_cyc_a.size() == 8) begin
         check("t1_first_valid", hs_cyc_a[0] - s, 3);
         check("t1_bubble", hs_cyc_a[4] - hs_cyc_a[3], 2);
         check("t1_back_to_back", hs_cyc_a[3] - hs_cyc_a[0], 3);
         check("t1_done_latency", done_cyc_a - hs_cyc_a[7], 1);
      end
`ifdef SPI_LOADER_UNPACK_CSUM_EN
      check("t1_csum", csum_a, 16'h0264);
      tick();
      check("t1_csum_hold", csum_a, 16'h0264);
`endif
      tick();

      // Backpressure on the C0 lane
      mem_a[2] = 32'hA0B0_C0D0;
      tail_a   = 3;
      ready_a  = 1'b0;
      start_xfer_a(16'd1);
      wait_valid_a("t2_valid", 10);
      check("t2_lane0", data_a, 8'hD0);
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_data", data_a, 8'hC0);
         check("t2_hold_valid", valid_a, 1);
         check("t2_no_rd", rd_a, 0);
         tick();
      end
      ready_a = 1'b1;
      wait_done_a("t2_done_seen", 20);
      check_log_a("t2_stream", 1, 32'hA0B0_C0D0, 32'h0);
      tick();

      // Empty FIFO gap between words, fill request raised
      mem_a[3] = 32'h0403_0201;
      mem_a[4] = 32'h0807_0605;
      tail_a   = 4;
      low_a    = 1'b1;
      start_xfer_a(16'd2);
      repeat (10) tick();
      for (int i = 0; i < 10; i++) begin
         check("t3_gap_valid", valid_a, 0);
         check("t3_fill", fill_a, 1);
         tick();
      end
      tail_a = 5;
      wait_done_a("t3_done_seen", 30);
      low_a = 1'b0;
      check_log_a("t3_stream", 2, 32'h0403_0201, 32'h0807_0605);
      tick();
      check("t3_fill_idle", fill_a, 0);

      // Zero-length transfer
      start_xfer_a(16'd0);
      check("t4_done", done_a, 1);
      check("t4_busy", busy_a, 0);
      check("t4_rd", rd_a, 0);
      tick();
      check("t4_done_once", done_a, 0);
      tick();

      // Restart while a read is in flight; the stale word must never appear
      mem_a[5] = 32'hDEAD_BEEF;
      mem_a[6] = 32'h1413_1211;
      mem_a[7] = 32'h1817_1615;
      tail_a   = 8;
      start_xfer_a(16'd2);
      tick();
      d0 = done_cnt_a;
      start_xfer_a(16'd2);
      check("t5_valid_after_restart", valid_a, 0);
      wait_done_a("t5_done_seen", 40);
      check("t5_single_done", done_cnt_a - d0, 1);
      check_log_a("t5_stream", 2, 32'h1413_1211, 32'h1817_1615);
      tick();

      // Asynchronous reset in the middle of a transfer
      mem_a[8]  = 32'h2423_2221;
      mem_a[9]  = 32'h2827_2625;
      mem_a[10] = 32'h3433_3231;
      mem_a[11] = 32'h3837_3635;
      tail_a    = 12;
      low_a     = 1'b1;
      start_xfer_a(16'd2);
      wait_valid_a("t6_valid", 10);
      tick();
      check("t6_busy_pre", busy_a, 1);
      check("t6_fill_pre", fill_a, 1);
      reset = 1'b1;
      #1;
      check("t6_valid", valid_a, 0);
      check("t6_data",  data_a, 0);
      check("t6_rd",    rd_a, 0);
      check("t6_fill",  fill_a, 0);
      check("t6_busy",  busy_a, 0);
      check("t6_done",  done_a, 0);
`ifdef SPI_LOADER_UNPACK_CSUM_EN
      check("t6_csum",  csum_a, 0);
`endif
      tick(); tick();
      reset = 1'b0;
      low_a = 1'b0;
      tick();
      check("t6_idle_busy", busy_a, 0);
      check("t6_idle_valid", valid_a, 0);
      start_xfer_a(16'd1);
      wait_done_a("t6_recover_done", 20);
      check("t6_recover_len", log_a.size(), 4);
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
